// File: rtl/adder_if.sv
// Operand/result bundle for the registered adder.
// The toggle_cnt signal exists only when ADDER_TOGGLE_CNT_EN is defined.
interface adder_if #(
    parameter int N     = 12,
    parameter int CNT_W = 32
);
    logic [N-1:0] input1;
    logic [N-1:0] input2;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         overflow;

`ifdef ADDER_TOGGLE_CNT_EN
    logic [CNT_W-1:0] toggle_cnt;

    modport master (
        output input1,
        output input2,
        input  sum,
        input  carry_out,
        input  overflow,
        input  toggle_cnt
    );

    modport slave (
        input  input1,
        input  input2,
        output sum,
        output carry_out,
        output overflow,
        output toggle_cnt
    );
`else
    modport master (
        output input1,
        output input2,
        input  sum,
        input  carry_out,
        input  overflow
    );

    modport slave (
        input  input1,
        input  input2,
        output sum,
        output carry_out,
        output overflow
    );
`endif

    if (N < 2 || CNT_W < 1) begin : g_param_check
        $error("adder_if: N must be >= 2 and CNT_W >= 1");
    end

endinterface

// File: rtl/adder.sv
// Registered N-bit adder: sum, carry_out and signed overflow one cycle after the operands.
// Optional macro ADDER_TOGGLE_CNT_EN adds a counter of sum-bit transitions (toggle_cnt).
module adder #(
    parameter int N     = 12,
    parameter int CNT_W = 32
) (
    input  logic   clk,
    input  logic   rst,
    adder_if.slave bus
);

    logic [N:0]   full_sum;
    logic [N-1:0] next_sum;
    logic         next_carry;
    logic         next_ovf;

    logic [N-1:0] sum_q;
    logic         carry_q;
    logic         ovf_q;

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        full_sum   = {1'b0, bus.input1} + {1'b0, bus.input2};
        next_sum   = full_sum[N-1:0];
        next_carry = full_sum[N];
        // Signed overflow: like-signed operands producing a result of the other sign.
        next_ovf   = (bus.input1[N-1] == bus.input2[N-1]) && (full_sum[N-1] != bus.input1[N-1]);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sum_q   <= next_sum;
            carry_q <= next_carry;
            ovf_q   <= next_ovf;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;

`ifdef ADDER_TOGGLE_CNT_EN
    logic [N-1:0]     sum_diff;
    logic [CNT_W-1:0] toggle_inc;
    logic [CNT_W-1:0] toggle_q;

    // Bits of the registered sum that change at the coming edge (relative to 0 when leaving reset).
    always_comb begin
        sum_diff   = next_sum ^ sum_q;
        toggle_inc = '0;
        for (int i = 0; i < N; i++) begin
            toggle_inc = toggle_inc + CNT_W'(sum_diff[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_q + toggle_inc;
        end
    end

    assign bus.toggle_cnt = toggle_q;
`endif

    if (N < 2 || CNT_W < 1) begin : g_param_check
        $error("adder: N must be >= 2 and CNT_W >= 1");
    end

endmodule

// File: tb/tb_adder.sv
// Directed self-checking bench for the registered adder (N=12).
// Toggle-counter checks run only when ADDER_TOGGLE_CNT_EN is defined.
module tb_adder;

    localparam int N     = 12;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    adder_if #(.N(N), .CNT_W(CNT_W)) bus ();

    adder #(.N(N), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("check %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Apply operands mid-cycle, then sample just after the next rising edge.
    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic r);
        @(negedge clk);
        rst        = r;
        bus.input1 = a;
        bus.input2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [N-1:0] s, input logic c, input logic o);
        check({tag, ".sum"},      32'(bus.sum),       32'(s));
        check({tag, ".carry"},    32'(bus.carry_out), 32'(c));
        check({tag, ".overflow"}, 32'(bus.overflow),  32'(o));
    endtask

    // Reference model in integer arithmetic, signed view taken separately.
    task automatic model(input int a, input int b, output logic [N-1:0] s, output logic c, output logic o);
        int total;
        int sa;
        int sb;
        int ss;
        total = a + b;
        s     = N'(total % 4096);
        c     = (total >= 4096);
        sa    = (a >= 2048) ? a - 4096 : a;
        sb    = (b >= 2048) ? b - 4096 : b;
        ss    = sa + sb;
        o     = (ss > 2047) || (ss < -2048);
    endtask

    initial begin
        logic [N-1:0] exp_sum;
        logic         exp_c;
        logic         exp_o;
        logic [N-1:0] prev_sum;
        int           a;
        int           b;

        rst        = 1'b1;
        bus.input1 = 12'hABC;
        bus.input2 = 12'h123;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_result("reset", 12'h000, 1'b0, 1'b0);
        end

        // First edge with rst low yields the operands sampled there.
        drive(12'h800, 12'hFFF, 1'b0);
        check_result("carry_800_fff", 12'h7FF, 1'b1, 1'b1);
        drive(12'h1FF, 12'h000, 1'b0);
        check_result("plain_1ff", 12'h1FF, 1'b0, 1'b0);
        drive(12'h1FF, 12'h000, 1'b0);
        check_result("hold_1ff", 12'h1FF, 1'b0, 1'b0);
        drive(12'hFFF, 12'hFFF, 1'b0);
        check_result("wrap_fff_fff", 12'hFFE, 1'b1, 1'b0);
        drive(12'hFFF, 12'h03F, 1'b0);
        check_result("wrap_fff_03f", 12'h03E, 1'b1, 1'b0);
        drive(12'h7FF, 12'h001, 1'b0);
        check_result("sovf_7ff_001", 12'h800, 1'b0, 1'b1);

        // Reset asserted mid-stream, then released.
        drive(12'h555, 12'h0AA, 1'b1);
        check_result("midreset", 12'h000, 1'b0, 1'b0);
        drive(12'h123, 12'h456, 1'b0);
        check_result("after_midreset", 12'h579, 1'b0, 1'b0);

        // Back-to-back stream: output must lag operands by exactly one edge.
        prev_sum = 12'h579;
        for (int i = 0; i < 27; i++) begin
            if (i < 20) begin
                a = (i * 32'h1F3 + 32'h0A5) % 4096;
                b = ((i * 32'h2C7) ^ 32'h5A5) % 4096;
            end else begin
                a = 0;
                b = 0;
            end
            @(negedge clk);
            bus.input1 = N'(a);
            bus.input2 = N'(b);
            #1;
            check("stream.no_comb_path", 32'(bus.sum), 32'(prev_sum));
            model(a, b, exp_sum, exp_c, exp_o);
            @(posedge clk);
            #1;
            check_result("stream", exp_sum, exp_c, exp_o);
            prev_sum = exp_sum;
        end
        check_result("stream_final", 12'h000, 1'b0, 1'b0);

`ifdef ADDER_TOGGLE_CNT_EN
        drive(12'h000, 12'h000, 1'b1);
        check("toggle.reset", bus.toggle_cnt, 32'd0);
        drive(12'h000, 12'hFFF, 1'b0);
        check("toggle.first", bus.toggle_cnt, 32'd12);
        drive(12'h000, 12'h000, 1'b0);
        check("toggle.second", bus.toggle_cnt, 32'd24);
        drive(12'h000, 12'h000, 1'b0);
        check("toggle.stable", bus.toggle_cnt, 32'd24);
        drive(12'h0F0, 12'h000, 1'b1);
        check("toggle.midreset", bus.toggle_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
